// File: rtl/fifo_ram.sv
// fifo_ram: single-clock FIFO built on a dual-port RAM array.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
// read_data is registered and updates only on an accepted read.
module fifo_ram #(
    parameter int ADDRBITS = 11,
    parameter int DATABITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATABITS-1:0] write_data,
    input  logic                write_en,
    output logic [DATABITS-1:0] read_data,
    input  logic                read_en,
    output logic                empty,
    output logic                full
);

    localparam int unsigned DEPTH = 1 << ADDRBITS;
    localparam logic [ADDRBITS:0] PTR_ONE = {{ADDRBITS{1'b0}}, 1'b1};

    logic [DATABITS-1:0] r_mem [DEPTH];
    logic [ADDRBITS:0]   r_wptr;
    logic [ADDRBITS:0]   r_rptr;
    logic [DATABITS-1:0] r_read_data;
    logic                w_empty;
    logic                w_full;
    logic                w_wr_accept;
    logic                w_rd_accept;

    // Flags and accept strobes are decoded from the registered pointers only
    always_comb begin
        w_empty     = (r_wptr == r_rptr);
        w_full      = (r_wptr[ADDRBITS-1:0] == r_rptr[ADDRBITS-1:0]) &&
                      (r_wptr[ADDRBITS] != r_rptr[ADDRBITS]);
        w_wr_accept = write_en && !w_full;
        w_rd_accept = read_en && !w_empty;
    end

    // RAM write port; no reset so the array can map onto block RAM
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wptr[ADDRBITS-1:0]] <= write_data;
        end
    end

    // Write pointer advances on every accepted write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
        end else if (w_wr_accept) begin
            r_wptr <= r_wptr + PTR_ONE;
        end
    end

    // Read pointer advances on every accepted read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr <= '0;
        end else if (w_rd_accept) begin
            r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // RAM read port; output holds its value unless a read is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data <= '0;
        end else if (w_rd_accept) begin
            r_read_data <= r_mem[r_rptr[ADDRBITS-1:0]];
        end
    end

    assign read_data = r_read_data;
    assign empty     = w_empty;
    assign full      = w_full;

endmodule

// File: tb/tb_fifo_ram.sv
// tb_fifo_ram: directed self-checking bench for fifo_ram (default 2048 x 8).
module tb_fifo_ram;

    localparam int AB    = 11;
    localparam int DB    = 8;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DB-1:0] wd  = '0;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [DB-1:0] rd;
    logic          empty;
    logic          full;

    int tests = 0;
    int fails = 0;

    fifo_ram #(.ADDRBITS(AB), .DATABITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_data(wd),
        .write_en  (we),
        .read_data (rd),
        .read_en   (re),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, leave outputs settled 1ns later
    task automatic cyc(input logic w, input logic [DB-1:0] d, input logic r);
        we = w;
        wd = d;
        re = r;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || rd !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: empty=%b full=%b rd=%h, want 1 0 00", empty, full, rd);
        end
        // requests while in reset must do nothing
        cyc(1'b1, 8'h99, 1'b1);
        cyc(1'b1, 8'h98, 1'b1);
        tests++;
        if (empty !== 1'b1 || rd !== 8'h00) begin
            fails++;
            $display("FAIL reset_ignores_req: empty=%b rd=%h, want 1 00", empty, rd);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        cyc(1'b1, 8'h07, 1'b0);
        tests++;
        if (empty !== 1'b0 || full !== 1'b0) begin
            fails++;
            $display("FAIL single_after_write: empty=%b full=%b, want 0 0", empty, full);
        end
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'h07 || empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL single_read: rd=%h empty=%b full=%b, want 07 1 0", rd, empty, full);
        end
    endtask

    task automatic test_hold_on_empty_read();
        cyc(1'b1, 8'hFA, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'hFA) begin
            fails++;
            $display("FAIL hold_first_read: rd=%h, want fa", rd);
        end
        cyc(1'b1, 8'h1B, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            tests++;
            if (rd !== 8'h1B) begin
                fails++;
                $display("FAIL hold_read%0d: rd=%h, want 1b", i, rd);
            end
        end
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL hold_end_empty: empty=%b, want 1", empty);
        end
    endtask

    task automatic test_empty_read();
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'h00 || empty !== 1'b1) begin
            fails++;
            $display("FAIL empty_read: rd=%h empty=%b, want 00 1", rd, empty);
        end
        // pointers must not have moved: one write then one read leaves empty
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'h11 || empty !== 1'b1) begin
            fails++;
            $display("FAIL empty_read_ptrs: rd=%h empty=%b, want 11 1", rd, empty);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == DEPTH - 2) begin
                tests++;
                if (full !== 1'b0) begin
                    fails++;
                    $display("FAIL fill_not_full_early: full=%b, want 0", full);
                end
            end
        end
        tests++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: full=%b empty=%b, want 1 0", full, empty);
        end
        cyc(1'b1, 8'hAA, 1'b0);
        tests++;
        if (full !== 1'b1 || rd !== 8'h11) begin
            fails++;
            $display("FAIL full_write_drop: full=%b rd=%h, want 1 11", full, rd);
        end
        // simultaneous at full: read taken, write dropped
        cyc(1'b1, 8'h77, 1'b1);
        tests++;
        if (rd !== 8'h00 || full !== 1'b0) begin
            fails++;
            $display("FAIL full_simul: rd=%h full=%b, want 00 0", rd, full);
        end
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            tests++;
            if (rd !== 8'(i)) begin
                fails++;
                $display("FAIL drain_word%0d: rd=%h, want %h", i, rd, 8'(i));
            end
        end
        tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: empty=%b full=%b, want 1 0", empty, full);
        end
        // dropped words must not surface
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'hFF) begin
            fails++;
            $display("FAIL drain_no_extra: rd=%h, want ff", rd);
        end
    endtask

    task automatic test_simul_empty();
        cyc(1'b1, 8'h55, 1'b1);
        tests++;
        if (rd !== 8'hFF || empty !== 1'b0) begin
            fails++;
            $display("FAIL empty_simul: rd=%h empty=%b, want ff 0", rd, empty);
        end
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'h55 || empty !== 1'b1) begin
            fails++;
            $display("FAIL empty_simul_read: rd=%h empty=%b, want 55 1", rd, empty);
        end
    endtask

    task automatic test_wrap();
        int exp;
        exp = 0;
        for (int j = 0; j < DEPTH / 2; j++) begin
            cyc(1'b1, 8'(j), 1'b0);
        end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            cyc(1'b1, 8'(DEPTH / 2 + k), 1'b1);
            tests++;
            if (rd !== 8'(exp) || empty !== 1'b0 || full !== 1'b0) begin
                fails++;
                $display("FAIL wrap_step%0d: rd=%h empty=%b full=%b, want %h 0 0",
                         k, rd, empty, full, 8'(exp));
            end
            exp++;
        end
        for (int j = 0; j < DEPTH / 2; j++) begin
            cyc(1'b0, 8'h00, 1'b1);
            tests++;
            if (rd !== 8'(exp)) begin
                fails++;
                $display("FAIL wrap_drain%0d: rd=%h, want %h", j, rd, 8'(exp));
            end
            exp++;
        end
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL wrap_end_empty: empty=%b, want 1", empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h81 + i), 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'h81) begin
            fails++;
            $display("FAIL midrst_pre: rd=%h, want 81", rd);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (empty !== 1'b1 || full !== 1'b0 || rd !== 8'h00) begin
            fails++;
            $display("FAIL midrst_async: empty=%b full=%b rd=%h, want 1 0 00", empty, full, rd);
        end
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'h3C, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (rd !== 8'h3C || empty !== 1'b1) begin
            fails++;
            $display("FAIL midrst_after: rd=%h empty=%b, want 3c 1", rd, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_on_empty_read();
        test_empty_read();
        test_fill_drain();
        test_simul_empty();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
